carfield_periph_apb_demux: RTL and testbench

//  Bridges a single 32-bit request/response port from the host crossbar "periph" window onto five APB slaves.
//  The APB slaves are CAN, system timer, advanced timer, watchdog and HyperBus cfg.

---
 rtl/carfield_periph_apb_demux.sv | 187 ++++++++++++++++++
 tb/tb_carfield_periph_apb_demux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_periph_apb_demux.sv
// carfield_periph_apb_demux
//   Bridges one 32-bit request/response port from the host crossbar "periph"
//   window onto five APB slaves: CAN, system timer, advanced timer, watchdog
//   and HyperBus cfg. It decodes the request address against the five 4 KiB
//   regions and runs an APB SETUP/ACCESS sequence on a hit. Unmapped or
//   disabled targets are answered with an error. A slave that stalls ACCESS
//   for TimeoutCycles cycles is abandoned and also answered with an error.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 request channel (valid/ready, addr, write, wdata, wstrb)
//   rsp_*                 response channel (valid/ready, rdata, error)
//   paddr_o .. pstrb_o    shared APB request signals; psel_o is one-hot per slave
//   pready_i, prdata_i,   per-slave APB response; prdata_i packed [32*i +: 32]
//   pslverr_i
module carfield_periph_apb_demux #(
  parameter bit          CanEnable     = 1'b1,
  parameter logic [31:0] CanBase       = 32'h2000_1000,
  parameter logic [31:0] TimerBase     = 32'h2000_4000,
  parameter logic [31:0] AdvTimerBase  = 32'h2000_5000,
  parameter logic [31:0] WdogBase      = 32'h2000_7000,
  parameter logic [31:0] HypCfgBase    = 32'h2000_8000,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  req_addr_i,
  input  logic         req_write_i,
  input  logic [31:0]  req_wdata_i,
  input  logic [3:0]   req_wstrb_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_rdata_o,
  output logic         rsp_error_o,
  output logic [31:0]  paddr_o,
  output logic [4:0]   psel_o,
  output logic         penable_o,
  output logic         pwrite_o,
  output logic [31:0]  pwdata_o,
  output logic [3:0]   pstrb_o,
  input  logic [4:0]   pready_i,
  input  logic [159:0] prdata_i,
  input  logic [4:0]   pslverr_i
);

  localparam int unsigned NumSlv       = 5;
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  // Index 0 is CAN, matching the psel_o bit order.
  localparam logic [NumSlv-1:0][31:0] SlvBase =
    {HypCfgBase, WdogBase, AdvTimerBase, TimerBase, CanBase};
  localparam logic [NumSlv-1:0] SlvEnable = {4'b1111, CanEnable};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e       state_q;
  logic         req_ready_q;
  logic         rsp_valid_q;
  logic [31:0]  rsp_rdata_q;
  logic         rsp_error_q;
  logic [31:0]  paddr_q;
  logic [4:0]   psel_q;
  logic         penable_q;
  logic         pwrite_q;
  logic [31:0]  pwdata_q;
  logic [3:0]   pstrb_q;
  logic [15:0]  cnt_q;
  logic [15:0]  cnt_d;

  logic [NumSlv-1:0]        hit;
  logic [NumSlv-1:0][31:0]  prdata_masked;
  logic [31:0]              prdata_sel;
  logic                     pready_sel;
  logic                     pslverr_sel;

  // Region decode on the 4 KiB page number.
  for (genvar gi = 0; gi < NumSlv; gi++) begin : g_dec
    assign hit[gi] = SlvEnable[gi] && (req_addr_i[31:12] == SlvBase[gi][31:12]);
  end

  // psel_q is one-hot while a transfer is on the bus (zero otherwise), so
  // masking with it both selects the active slave and ignores all others.
  for (genvar gi = 0; gi < NumSlv; gi++) begin : g_rdmask
    assign prdata_masked[gi] = prdata_i[32*gi +: 32] & {32{psel_q[gi]}};
  end

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NumSlv; i++) begin
      prdata_sel = prdata_sel | prdata_masked[i];
    end
  end

  assign pready_sel  = |(pready_i & psel_q);
  assign pslverr_sel = |(pslverr_i & psel_q);
  assign cnt_d       = cnt_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Ready comes up one cycle after reset release and stays up in IDLE.
          req_ready_q <= 1'b1;
          if (req_ready_q && req_valid_i) begin
            req_ready_q <= 1'b0;
            if (|hit) begin
              paddr_q  <= {20'h0, req_addr_i[11:0]};
              pwrite_q <= req_write_i;
              pwdata_q <= req_wdata_i;
              pstrb_q  <= req_write_i ? req_wstrb_i : 4'h0;
              psel_q   <= hit;
              cnt_q    <= '0;
              state_q  <= SETUP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_sel) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= pslverr_sel;
            rsp_rdata_q <= (pwrite_q || pslverr_sel) ? 32'h0 : prdata_sel;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
            // Abort once the stall has lasted TimeoutCycles ACCESS cycles.
            if (cnt_d == TimeoutLimit) begin
              psel_q      <= '0;
              penable_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule

// File: tb/tb_carfield_periph_apb_demux.sv
// Testbench for carfield_periph_apb_demux. dut_a: CAN enabled, timeout 8.
// dut_b: CAN disabled, default timeout; used only for the disabled-CAN access.
module tb_carfield_periph_apb_demux;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;     // ACCESS cycles before pready (>=1000: never)
    logic        slverr;
    logic [31:0] prd;
    logic        use_b;
    logic [4:0]  exp_psel;
    int          exp_lat;   // cycles from accept cycle to first rsp_valid
    int          exp_acc;   // cycles with penable high
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          hold;      // cycles rsp_ready held low
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel_b = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_write = 1'b0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_wstrb = '0;
  logic         rsp_ready = 1'b0;
  logic [4:0]   pready = '0;
  logic [159:0] prdata = '0;
  logic [4:0]   pslverr = '0;

  logic req_ready_a, rsp_valid_a, rsp_error_a, penable_a, pwrite_a;
  logic req_ready_b, rsp_valid_b, rsp_error_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_a, paddr_a, pwdata_a, rsp_rdata_b, paddr_b, pwdata_b;
  logic [4:0] psel_a, psel_b;
  logic [3:0] pstrb_a, pstrb_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carfield_periph_apb_demux #(.CanEnable(1'b1), .TimeoutCycles(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel_b), .req_ready_o(req_ready_a),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_a), .rsp_error_o(rsp_error_a), .paddr_o(paddr_a),
    .psel_o(psel_a), .penable_o(penable_a), .pwrite_o(pwrite_a), .pwdata_o(pwdata_a),
    .pstrb_o(pstrb_a), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr));

  carfield_periph_apb_demux #(.CanEnable(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel_b), .req_ready_o(req_ready_b),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb), .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_b), .rsp_error_o(rsp_error_b), .paddr_o(paddr_b),
    .psel_o(psel_b), .penable_o(penable_b), .pwrite_o(pwrite_b), .pwdata_o(pwdata_b),
    .pstrb_o(pstrb_b), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr));

  wire        m_req_ready = sel_b ? req_ready_b : req_ready_a;
  wire        m_rsp_valid = sel_b ? rsp_valid_b : rsp_valid_a;
  wire        m_rsp_error = sel_b ? rsp_error_b : rsp_error_a;
  wire [31:0] m_rsp_rdata = sel_b ? rsp_rdata_b : rsp_rdata_a;
  wire [31:0] m_paddr     = sel_b ? paddr_b : paddr_a;
  wire [4:0]  m_psel      = sel_b ? psel_b : psel_a;
  wire        m_penable   = sel_b ? penable_b : penable_a;
  wire        m_pwrite    = sel_b ? pwrite_b : pwrite_a;
  wire [31:0] m_pwdata    = sel_b ? pwdata_b : pwdata_a;
  wire [3:0]  m_pstrb     = sel_b ? pstrb_b : pstrb_a;

  wire all_out_or = |{m_req_ready, m_rsp_valid, m_rsp_error, m_rsp_rdata, m_paddr,
                      m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave side: non-selected slaves assert ready/error to prove they are ignored.
  task automatic drive_slaves(input vec_t v, input bit ready_now);
    for (int s = 0; s < 5; s++) begin
      prdata[32*s +: 32] = v.exp_psel[s] ? v.prd : (32'hBAD0_0000 | 32'(s));
    end
    pready  = ready_now ? 5'b11111 : ~v.exp_psel;
    pslverr = ~v.exp_psel | (v.slverr ? v.exp_psel : 5'b0);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int cyc;
    int acc;
    bit acc_ok;
    bit bus_bad;
    bit hold_bad;
    logic [4:0]  psel_seen;
    logic [31:0] rd0;
    logic        er0;
    sel_b     = v.use_b;
    req_addr  = v.addr;
    req_write = v.wr;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    rsp_ready = 1'b0;
    drive_slaves(v, 1'b0);
    req_valid = 1'b1;
    acc_ok = 1'b0;
    for (int k = 0; k < 20 && !acc_ok; k++) begin
      if (m_req_ready) acc_ok = 1'b1;
      step();
    end
    req_valid = 1'b0;
    if (!acc_ok) begin
      check({tag, "_accept"}, 32'd0, 32'd1);
      return;
    end
    cyc = 1; acc = 0; bus_bad = 1'b0; psel_seen = '0;
    while (!m_rsp_valid && cyc < 60) begin
      psel_seen |= m_psel;
      if (m_psel != 5'b0) begin
        if (m_paddr !== {20'h0, v.addr[11:0]} || m_pwrite !== v.wr ||
            m_pstrb !== (v.wr ? v.wstrb : 4'h0) || (v.wr && m_pwdata !== v.wdata))
          bus_bad = 1'b1;
      end
      if (m_penable) begin
        acc++;
        if (acc > v.waits) drive_slaves(v, 1'b1);
      end
      step();
      cyc++;
      drive_slaves(v, 1'b0);
    end
    if (!m_rsp_valid) begin
      check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(v.exp_lat));
    check({tag, "_psel"}, {27'h0, psel_seen}, {27'h0, v.exp_psel});
    check({tag, "_penable_cycles"}, 32'(acc), 32'(v.exp_acc));
    check({tag, "_err"}, {31'h0, m_rsp_error}, {31'h0, v.exp_err});
    check({tag, "_rdata"}, m_rsp_rdata, v.exp_rdata);
    check({tag, "_bus_idle_in_resp"}, {26'h0, m_psel, m_penable}, 32'h0);
    check({tag, "_ready_in_resp"}, {31'h0, m_req_ready}, 32'h0);
    if (v.exp_psel != 5'b0) check({tag, "_apb_stable"}, {31'h0, bus_bad}, 32'h0);
    rd0 = m_rsp_rdata; er0 = m_rsp_error; hold_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      step();
      if (!m_rsp_valid || m_rsp_rdata !== rd0 || m_rsp_error !== er0 || m_req_ready)
        hold_bad = 1'b1;
    end
    if (v.hold > 0) check({tag, "_rsp_hold"}, {31'h0, hold_bad}, 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'h0, m_rsp_valid}, 32'h0);
    $display("txn %s addr=%h wr=%0d lat=%0d psel=%b err=%0d rdata=%h",
             tag, v.addr, v.wr, cyc, psel_seen, er0, rd0);
    pready = '0; pslverr = '0;
  endtask

  vec_t vecs[13];
  vec_t t6v;

  initial begin
    int bad;
    //         addr          wr    wdata          wstrb waits slverr prd          b     psel      lat acc err   rdata          hold
    vecs[0]  = '{32'h2000_4010, 1'b0, 32'hAAAA_5555, 4'hF, 0,    1'b0, 32'hCAFE_0001, 1'b0, 5'b00010, 3,  1, 1'b0, 32'hCAFE_0001, 0};
    vecs[1]  = '{32'h2000_8004, 1'b1, 32'h1234_5678, 4'h3, 4,    1'b0, 32'hFFFF_FFFF, 1'b0, 5'b10000, 7,  5, 1'b0, 32'h0,         0};
    vecs[2]  = '{32'h2000_2000, 1'b0, 32'h0,         4'hF, 0,    1'b0, 32'h1111_1111, 1'b0, 5'b00000, 1,  0, 1'b1, 32'h0,         0};
    vecs[3]  = '{32'h2000_3FFC, 1'b1, 32'h0000_0055, 4'h1, 0,    1'b0, 32'h2222_2222, 1'b0, 5'b00000, 1,  0, 1'b1, 32'h0,         1};
    vecs[4]  = '{32'h2000_6000, 1'b0, 32'h0,         4'h0, 0,    1'b0, 32'h3333_3333, 1'b0, 5'b00000, 1,  0, 1'b1, 32'h0,         0};
    vecs[5]  = '{32'h2000_1000, 1'b0, 32'h0,         4'h0, 0,    1'b0, 32'h4444_4444, 1'b1, 5'b00000, 1,  0, 1'b1, 32'h0,         0};
    vecs[6]  = '{32'h2000_7008, 1'b0, 32'h0,         4'h0, 1000, 1'b0, 32'h5555_5555, 1'b0, 5'b01000, 10, 8, 1'b1, 32'h0,         0};
    vecs[7]  = '{32'h2000_5020, 1'b0, 32'h0,         4'h0, 0,    1'b1, 32'hDEAD_BEEF, 1'b0, 5'b00100, 3,  1, 1'b1, 32'h0,         3};
    vecs[8]  = '{32'h2000_1FFC, 1'b0, 32'h0,         4'h0, 1,    1'b0, 32'h0BAD_F00D, 1'b0, 5'b00001, 4,  2, 1'b0, 32'h0BAD_F00D, 1};
    vecs[9]  = '{32'h2000_4000, 1'b1, 32'hCAFE_BABE, 4'hF, 2,    1'b1, 32'h6666_6666, 1'b0, 5'b00010, 5,  3, 1'b1, 32'h0,         0};
    vecs[10] = '{32'h2000_0FFC, 1'b0, 32'h0,         4'h0, 0,    1'b0, 32'h7777_7777, 1'b0, 5'b00000, 1,  0, 1'b1, 32'h0,         0};
    vecs[11] = '{32'h2000_8FFF, 1'b0, 32'h0,         4'h0, 7,    1'b0, 32'h7777_0001, 1'b0, 5'b10000, 10, 8, 1'b0, 32'h7777_0001, 0};
    vecs[12] = '{32'h2000_9000, 1'b1, 32'h0000_0009, 4'hF, 0,    1'b0, 32'h8888_8888, 1'b0, 5'b00000, 1,  0, 1'b1, 32'h0,         0};
    t6v      = '{32'h2000_4ABC, 1'b0, 32'h0,         4'h0, 0,    1'b0, 32'h600D_0006, 1'b0, 5'b00010, 3,  1, 1'b0, 32'h600D_0006, 0};

    // Reset state
    rst = 1'b1;
    step(); step(); step();
    check("reset_outputs_zero", {31'h0, all_out_or}, 32'h0);
    rst = 1'b0;
    step();
    check("ready_after_reset", {31'h0, m_req_ready}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i], $sformatf("v%0d", i));
      if (i == 6) begin
        // Late pready from the timed-out watchdog must not produce a response.
        bad = 0;
        pready = 5'b01000;
        for (int k = 0; k < 4; k++) begin
          step();
          pready = 5'b0;
          if (m_rsp_valid || m_psel != 5'b0) bad++;
        end
        check("late_pready_ignored", 32'(bad), 32'h0);
        check("late_pready_idle_ready", {31'h0, m_req_ready}, 32'h1);
        $display("txn late_pready_pulse wdog bad_cycles=%0d", bad);
      end
    end

    // Reset in the middle of a CAN read ACCESS phase.
    sel_b = 1'b0;
    req_addr = 32'h2000_1100; req_write = 1'b0; req_wdata = 32'hA5A5_A5A5; req_wstrb = 4'hF;
    pready = '0; pslverr = '0; req_valid = 1'b1;
    bad = 1;
    for (int k = 0; k < 20 && bad != 0; k++) begin
      if (m_req_ready) bad = 0;
      step();
    end
    req_valid = 1'b0;
    check("t6_accept", 32'(bad), 32'h0);
    step();
    check("t6_in_access", {26'h0, m_psel, m_penable}, {26'h0, 5'b00001, 1'b1});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_outputs_zero", {31'h0, all_out_or}, 32'h0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (m_rsp_valid || m_psel != 5'b0) bad++;
    end
    check("t6_no_response", 32'(bad), 32'h0);
    $display("txn t6_reset_mid_access dropped_rsp_cycles=%0d", bad);
    do_txn(t6v, "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
